// File: rtl/ravan_block_packer_if.sv
// Byte-in / block-out handshake bundle for the RAVAN block packer.
// slave = packer side, master = host/core side.
interface ravan_block_packer_if;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic [63:0] m_data;
    logic        m_valid;
    logic        m_last;
    logic [3:0]  m_bytes;
    logic        m_ready;

    modport slave (
        input  s_data, s_valid, s_last, m_ready,
        output s_ready, m_data, m_valid, m_last, m_bytes
    );

    modport master (
        output s_data, s_valid, s_last, m_ready,
        input  s_ready, m_data, m_valid, m_last, m_bytes
    );
endinterface

// File: rtl/ravan_block_packer.sv
// Packs a byte stream big-endian into 64-bit blocks and queues them in a small FIFO.
// Defining RAVAN_PAD_EN adds 0x80 terminator padding and the FLUSH pad-block state.
module ravan_block_packer #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    ravan_block_packer_if.slave        bus,
    output logic [15:0]                frame_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

`ifdef RAVAN_PAD_EN
    typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, FLUSH = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1} state_t;
`endif

    state_t      state_r;
    state_t      state_s;
    logic [2:0]  cnt_r;
    logic [2:0]  cnt_s;
    logic [55:0] partial_r;
    logic [55:0] partial_s;

    logic [2:0]  lane_s;
    logic [63:0] word_s;
    logic [63:0] push_data_s;
    logic [3:0]  push_bytes_s;
    logic        push_last_s;
    logic        push_req_s;

    logic [63:0] mem_data_r  [DEPTH];
    logic [3:0]  mem_bytes_r [DEPTH];
    logic        mem_last_r  [DEPTH];
    logic [AW:0] wr_ptr_r;
    logic [AW:0] rd_ptr_r;
    logic [AW:0] wr_ptr_s;
    logic [AW:0] rd_ptr_s;

    logic        full_s;
    logic        empty_s;
    logic        full_nxt_s;
    logic        accept_s;
    logic        push_s;
    logic        pop_s;
    logic        s_ready_r;
    logic [15:0] frame_cnt_r;

    assign full_s   = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign empty_s  = (wr_ptr_r == rd_ptr_r);
    assign accept_s = bus.s_valid && s_ready_r;
    assign push_s   = push_req_s && !full_s;
    assign pop_s    = !empty_s && bus.m_ready;
    assign wr_ptr_s = push_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
    assign rd_ptr_s = pop_s  ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
    assign full_nxt_s = (wr_ptr_s[AW] != rd_ptr_s[AW]) && (wr_ptr_s[AW-1:0] == rd_ptr_s[AW-1:0]);

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE, FILL: begin
                if (accept_s && (bus.s_last || (cnt_r == 3'd7))) begin
`ifdef RAVAN_PAD_EN
                    if (bus.s_last && (cnt_r == 3'd7)) begin
                        state_s = FLUSH;
                    end else begin
                        state_s = IDLE;
                    end
`else
                    state_s = IDLE;
`endif
                end else if (accept_s) begin
                    state_s = FILL;
                end else begin
                    state_s = state_r;
                end
            end
`ifdef RAVAN_PAD_EN
            FLUSH: begin
                if (!full_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = FLUSH;
                end
            end
`endif
            default: state_s = IDLE;
        endcase
    end

    // FSM outputs: assemble the outgoing word and decide push / partial update
    always_comb begin
        lane_s = 3'd7 - cnt_r;
        word_s = {partial_r, 8'h00};
        word_s[{lane_s, 3'b000} +: 8] = bus.s_data;
`ifdef RAVAN_PAD_EN
        // Terminator goes in the lane right after the final data byte, if one is left.
        word_s = word_s | ((bus.s_last && (lane_s != 3'd0))
                           ? ({56'd0, 8'h80} << {lane_s - 3'd1, 3'b000}) : 64'd0);
`endif
        push_req_s   = 1'b0;
        push_data_s  = word_s;
        push_bytes_s = {1'b0, cnt_r} + 4'd1;
        push_last_s  = bus.s_last;
        cnt_s        = cnt_r;
        partial_s    = partial_r;
        case (state_r)
            IDLE, FILL: begin
                if (accept_s && (bus.s_last || (cnt_r == 3'd7))) begin
                    push_req_s = 1'b1;
                    cnt_s      = 3'd0;
                    partial_s  = 56'd0;
`ifdef RAVAN_PAD_EN
                    if (cnt_r == 3'd7) begin
                        push_last_s = 1'b0;
                    end else begin
                        push_last_s = bus.s_last;
                    end
`endif
                end else if (accept_s) begin
                    cnt_s     = cnt_r + 3'd1;
                    partial_s = word_s[63:8];
                end else begin
                    cnt_s     = cnt_r;
                    partial_s = partial_r;
                end
            end
`ifdef RAVAN_PAD_EN
            FLUSH: begin
                push_req_s   = !full_s;
                push_data_s  = 64'h8000_0000_0000_0000;
                push_bytes_s = 4'd0;
                push_last_s  = 1'b1;
            end
`endif
            default: begin
                cnt_s     = 3'd0;
                partial_s = 56'd0;
            end
        endcase
    end

    // Partial block and byte count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r     <= 3'd0;
            partial_r <= 56'd0;
        end else begin
            cnt_r     <= cnt_s;
            partial_r <= partial_s;
        end
    end

    // FIFO storage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_data_r[i]  <= 64'd0;
                mem_bytes_r[i] <= 4'd0;
                mem_last_r[i]  <= 1'b0;
            end
        end else if (push_s) begin
            mem_data_r[wr_ptr_r[AW-1:0]]  <= push_data_s;
            mem_bytes_r[wr_ptr_r[AW-1:0]] <= push_bytes_s;
            mem_last_r[wr_ptr_r[AW-1:0]]  <= push_last_s;
        end
    end

    // FIFO pointers and the registered s_ready, computed from next-cycle occupancy/state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r  <= '0;
            rd_ptr_r  <= '0;
            s_ready_r <= 1'b0;
        end else begin
            wr_ptr_r  <= wr_ptr_s;
            rd_ptr_r  <= rd_ptr_s;
`ifdef RAVAN_PAD_EN
            s_ready_r <= !full_nxt_s && (state_s != FLUSH);
`else
            s_ready_r <= !full_nxt_s;
`endif
        end
    end

    // Completed-frame counter, wraps naturally at 16 bits
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cnt_r <= 16'd0;
        end else if (pop_s && mem_last_r[rd_ptr_r[AW-1:0]]) begin
            frame_cnt_r <= frame_cnt_r + 16'd1;
        end
    end

    assign bus.s_ready = s_ready_r;
    assign bus.m_valid = !empty_s;
    assign bus.m_data  = empty_s ? 64'd0 : mem_data_r[rd_ptr_r[AW-1:0]];
    assign bus.m_bytes = empty_s ? 4'd0  : mem_bytes_r[rd_ptr_r[AW-1:0]];
    assign bus.m_last  = empty_s ? 1'b0  : mem_last_r[rd_ptr_r[AW-1:0]];
    assign frame_cnt   = frame_cnt_r;

endmodule

// File: tb/tb_ravan_block_packer.sv
// Directed bench for ravan_block_packer: vector table plus hand-written multi-cycle sequences.
module tb_ravan_block_packer;
    logic        clk;
    logic        rst;
    logic [15:0] frame_cnt;
    int          n_cmp;
    int          n_bad;

    ravan_block_packer_if bus ();

    ravan_block_packer #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .frame_cnt (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  d;
        logic        v;
        logic        l;
        logic        r;
        logic        srdy;
        logic        mval;
        logic [63:0] mdata;
        logic [3:0]  mbytes;
        logic        mlast;
        logic [15:0] fcnt;
    } vec_t;

    vec_t vecs[$];

`ifdef RAVAN_PAD_EN
    localparam logic [63:0] EXP_B = 64'hAABBCC8000000000;
    localparam logic [63:0] EXP_C = 64'h1080000000000000;
    localparam logic [63:0] EXP_D = 64'hF1F2F3F4F5F6F780;
`else
    localparam logic [63:0] EXP_B = 64'hAABBCC0000000000;
    localparam logic [63:0] EXP_C = 64'h1000000000000000;
    localparam logic [63:0] EXP_D = 64'hF1F2F3F4F5F6F700;
`endif

    function automatic vec_t mk(logic [7:0] d, logic v, logic l, logic r, logic srdy, logic mval,
                                logic [63:0] mdata, logic [3:0] mbytes, logic mlast, logic [15:0] fcnt);
        vec_t t;
        t.d = d; t.v = v; t.l = l; t.r = r; t.srdy = srdy; t.mval = mval;
        t.mdata = mdata; t.mbytes = mbytes; t.mlast = mlast; t.fcnt = fcnt;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [7:0] d, input logic v, input logic l, input logic r);
        bus.s_data  = d;
        bus.s_valid = v;
        bus.s_last  = l;
        bus.m_ready = r;
    endtask

    initial begin
        logic [63:0] exp_blk;
        int          acc;
        int          pops;
        int          cyc;
        bit          seen_ffff;

        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b0;
        drive(8'h00, 1'b0, 1'b0, 1'b0);

        // ---- reset state ----
        #1;
        chk("rst s_ready", {63'd0, bus.s_ready}, 64'd0);
        chk("rst m_valid", {63'd0, bus.m_valid}, 64'd0);
        chk("rst m_data", bus.m_data, 64'd0);
        chk("rst m_bytes", {60'd0, bus.m_bytes}, 64'd0);
        chk("rst m_last", {63'd0, bus.m_last}, 64'd0);
        chk("rst frame_cnt", {48'd0, frame_cnt}, 64'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("post-rst s_ready", {63'd0, bus.s_ready}, 64'd1);

        // ---- vector table: each entry is driven for one cycle, outputs checked after the edge ----
        for (int i = 0; i < 7; i++)
            vecs.push_back(mk(8'(i + 1), 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 64'd0, 4'd0, 1'b0, 16'd0));
        vecs.push_back(mk(8'h08, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 64'h0102030405060708, 4'd8, 1'b0, 16'd0));
        vecs.push_back(mk(8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 64'd0, 4'd0, 1'b0, 16'd0));
        vecs.push_back(mk(8'hAA, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 64'd0, 4'd0, 1'b0, 16'd0));
        vecs.push_back(mk(8'hBB, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 64'd0, 4'd0, 1'b0, 16'd0));
        vecs.push_back(mk(8'hCC, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, EXP_B, 4'd3, 1'b1, 16'd0));
        vecs.push_back(mk(8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 64'd0, 4'd0, 1'b0, 16'd1));
        vecs.push_back(mk(8'h10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, EXP_C, 4'd1, 1'b1, 16'd1));
        vecs.push_back(mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, EXP_C, 4'd1, 1'b1, 16'd1));
        vecs.push_back(mk(8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 64'd0, 4'd0, 1'b0, 16'd2));
        for (int i = 0; i < 6; i++)
            vecs.push_back(mk(8'(8'hF1 + i), 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 64'd0, 4'd0, 1'b0, 16'd2));
        vecs.push_back(mk(8'hF7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, EXP_D, 4'd7, 1'b1, 16'd2));
        vecs.push_back(mk(8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 64'd0, 4'd0, 1'b0, 16'd3));

        foreach (vecs[i]) begin
            drive(vecs[i].d, vecs[i].v, vecs[i].l, vecs[i].r);
            tick();
            chk($sformatf("v%0d s_ready", i), {63'd0, bus.s_ready}, {63'd0, vecs[i].srdy});
            chk($sformatf("v%0d m_valid", i), {63'd0, bus.m_valid}, {63'd0, vecs[i].mval});
            chk($sformatf("v%0d m_data", i), bus.m_data, vecs[i].mdata);
            chk($sformatf("v%0d frame_cnt", i), {48'd0, frame_cnt}, {48'd0, vecs[i].fcnt});
            if (vecs[i].mval) begin
                chk($sformatf("v%0d m_bytes", i), {60'd0, bus.m_bytes}, {60'd0, vecs[i].mbytes});
                chk($sformatf("v%0d m_last", i), {63'd0, bus.m_last}, {63'd0, vecs[i].mlast});
            end
        end

        // ---- full block ending a frame ----
        for (int k = 0; k < 8; k++) begin
            drive(8'(8'h11 * (k + 1)), 1'b1, (k == 7), 1'b1);
            tick();
        end
        drive(8'h00, 1'b0, 1'b0, 1'b1);
        chk("full8 m_data", bus.m_data, 64'h1122334455667788);
        chk("full8 m_bytes", {60'd0, bus.m_bytes}, 64'd8);
`ifdef RAVAN_PAD_EN
        chk("full8 m_last", {63'd0, bus.m_last}, 64'd0);
        chk("full8 s_ready low", {63'd0, bus.s_ready}, 64'd0);
        tick();
        chk("pad m_valid", {63'd0, bus.m_valid}, 64'd1);
        chk("pad m_data", bus.m_data, 64'h8000000000000000);
        chk("pad m_bytes", {60'd0, bus.m_bytes}, 64'd0);
        chk("pad m_last", {63'd0, bus.m_last}, 64'd1);
        chk("pad s_ready back", {63'd0, bus.s_ready}, 64'd1);
        chk("pad frame_cnt", {48'd0, frame_cnt}, 64'd3);
        tick();
`else
        chk("full8 m_last", {63'd0, bus.m_last}, 64'd1);
        chk("full8 s_ready", {63'd0, bus.s_ready}, 64'd1);
        tick();
`endif
        chk("full8 drained", {63'd0, bus.m_valid}, 64'd0);
        chk("full8 frame_cnt", {48'd0, frame_cnt}, 64'd4);

        // ---- backpressure: 40 bytes offered with m_ready low, only 32 fit ----
        acc = 0;
        for (int c = 0; c < 45; c++) begin
            logic take;
            drive(8'(acc + 1), (acc < 40), 1'b0, 1'b0);
            take = bus.s_valid && bus.s_ready;
            tick();
            if (take) acc++;
        end
        chk("bp accepted", 64'(acc), 64'd32);
        chk("bp s_ready low", {63'd0, bus.s_ready}, 64'd0);
        chk("bp m_valid", {63'd0, bus.m_valid}, 64'd1);
        chk("bp head0", bus.m_data, 64'h0102030405060708);
        drive(8'h00, 1'b0, 1'b0, 1'b1);
        for (int b = 1; b <= 4; b++) begin
            tick();
            chk($sformatf("bp s_ready after pop%0d", b), {63'd0, bus.s_ready}, 64'd1);
            if (b < 4) begin
                exp_blk = 64'd0;
                for (int j = 0; j < 8; j++) exp_blk = {exp_blk[55:0], 8'(8 * b + j + 1)};
                chk($sformatf("bp head%0d", b), bus.m_data, exp_blk);
            end else begin
                chk("bp drained", {63'd0, bus.m_valid}, 64'd0);
            end
        end

        // ---- reset mid-frame with a block queued ----
        for (int k = 0; k < 13; k++) begin
            drive(8'(8'hE0 + k), 1'b1, 1'b0, 1'b0);
            tick();
        end
        drive(8'h00, 1'b0, 1'b0, 1'b0);
        chk("pre-rst m_valid", {63'd0, bus.m_valid}, 64'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("mid-rst m_valid", {63'd0, bus.m_valid}, 64'd0);
        chk("mid-rst m_data", bus.m_data, 64'd0);
        chk("mid-rst m_bytes", {60'd0, bus.m_bytes}, 64'd0);
        chk("mid-rst m_last", {63'd0, bus.m_last}, 64'd0);
        chk("mid-rst frame_cnt", {48'd0, frame_cnt}, 64'd0);
        chk("mid-rst s_ready", {63'd0, bus.s_ready}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("re-rst s_ready", {63'd0, bus.s_ready}, 64'd1);
        for (int k = 0; k < 8; k++) begin
            drive(8'(k + 1), 1'b1, 1'b0, 1'b1);
            tick();
        end
        drive(8'h00, 1'b0, 1'b0, 1'b1);
        chk("re-rst m_data", bus.m_data, 64'h0102030405060708);
        chk("re-rst m_bytes", {60'd0, bus.m_bytes}, 64'd8);
        tick();
        chk("re-rst drained", {63'd0, bus.m_valid}, 64'd0);

        // ---- 65536 single-byte frames: frame_cnt wraps to 0 ----
        acc = 0;
        pops = 0;
        cyc = 0;
        seen_ffff = 1'b0;
        while ((pops < 65536) && (cyc < 70000)) begin
            logic take;
            logic popl;
            drive(8'h5A, (acc < 65536), 1'b1, 1'b1);
            take = bus.s_valid && bus.s_ready;
            popl = bus.m_valid && bus.m_ready && bus.m_last;
            tick();
            cyc++;
            if (take) acc++;
            if (popl) pops++;
            if ((pops == 65535) && !seen_ffff) begin
                seen_ffff = 1'b1;
                chk("wrap at 0xFFFF", {48'd0, frame_cnt}, 64'h0000_0000_0000_FFFF);
            end
        end
        drive(8'h00, 1'b0, 1'b0, 1'b1);
        chk("wrap finished in budget", 64'(pops), 64'd65536);
        chk("wrap frame_cnt", {48'd0, frame_cnt}, 64'd0);
        chk("wrap drained", {63'd0, bus.m_valid}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ravan_block_packer.md
# ravan_block_packer

Input-side stage of the RAVAN 512-bit crypto engine. It accepts the plaintext/ciphertext byte stream from the host interface, packs bytes big-endian into 64-bit blocks, buffers them in a small FIFO, and presents them with a valid/ready handshake to the 64-bit `data_in` port of the encryption/decryption core. It handles frame boundaries (`s_last`) and, optionally, block padding. The core only ever receives whole 64-bit words.

## Interface
- `DEPTH`, default 4: FIFO depth in 64-bit words. Must be a power of 2 and ≥ 2.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-low reset. The polarity and synchronicity are fixed.
- `s_data` input 8: incoming byte.
- `s_valid` input 1: byte valid.
- `s_last` input 1: the byte is the final byte of a frame. Sampled only on accept.
- `s_ready` output 1: the packer can accept a byte.
- `m_data` output 64: block at the FIFO head, with the first byte in [63:56]. Reads 0 when the FIFO is empty.
- `m_valid` output 1: the FIFO is non-empty.
- `m_last` output 1: the head block ends a frame.
- `m_bytes` output 4: number of payload bytes in the head block, 0..8.
- `m_ready` input 1: the core consumes the head block.
- `frame_cnt` output 16: count of completed `m_last` handshakes. Wraps from 0xFFFF to 0.

## Operation
- A byte is accepted when `s_valid & s_ready`. A block is consumed when `m_valid & m_ready`.
- The packer holds a 56-bit partial register and a byte count `cnt` in 0..7. The accepted byte is written at lane `7-cnt`.
- FSM states:
  - IDLE: `cnt`=0. An accepted byte moves the FSM to FILL. If that byte has `s_last` set, the block is pushed immediately and the FSM stays in IDLE.
  - FILL: `cnt`=1..7. The block is pushed when the 8th byte arrives, with `m_bytes`=8; `cnt` then returns to 0 and the FSM goes to IDLE. The block is also pushed on an accepted `s_last`.
  - FLUSH: exists only with padding enabled (see Configuration). Emits one extra pad block, then returns to IDLE.
- Push: the complete word is formed combinationally from the partial register plus the incoming byte and written to the FIFO in the same cycle. Unfilled low lanes are zero.
- `s_ready` = `!full && state != FLUSH`. There is no full-FIFO bypass: a pop in the same cycle does not make room for that cycle's push.
- Simultaneous push and pop on a non-full FIFO: both take effect and the occupancy is unchanged.
- Pointers are log2(DEPTH)+1 bits, so full and empty are distinguished by the wrap bit.
- `frame_cnt` increments on every handshake where `m_last`=1.
- Reset mid-frame discards the partial block and the FIFO contents; `frame_cnt` is cleared to 0.

## Timing
- Values during and immediately after reset:
  - `m_data` = 0, `m_valid` = 0, `m_last` = 0, `m_bytes` = 0, `frame_cnt` = 0.
  - `s_ready` = 0 while `rst` is low, and 1 in the first cycle after release.
- Latency: a block pushed at edge N is visible with `m_valid`=1 in the cycle after edge N, i.e. one cycle.
- Throughput: one byte per cycle; one block per 8 cycles in steady state.
- `m_*` outputs are stable while `m_valid & !m_ready`.
- FLUSH lasts at least one cycle, and stays while the FIFO is full. The pad block is pushed on the first cycle in which the FIFO is not full.

## Configuration
- `RAVAN_PAD_EN` defined:
  - On an accepted `s_last` with `cnt`<7, byte 0x80 is written to the next lane after the last data byte, and the remaining lanes are 0. `m_bytes` carries the payload count and `m_last`=1.
  - On `s_last` with `cnt`=7 (a full block), the data block is pushed with `m_bytes`=8 and `m_last`=0. The FSM then enters FLUSH and pushes 0x8000_0000_0000_0000 with `m_bytes`=0 and `m_last`=1.
- `RAVAN_PAD_EN` undefined:
  - The FLUSH state is not generated.
  - Partial blocks are zero-filled, and the last block always carries `m_last`=1.

## Test plan
- Reset release, then 8 bytes 0x01..0x08 with `m_ready`=1 → `m_data`=0x0102030405060708, `m_bytes`=8, `m_last`=0, one cycle after the 8th byte.
- 3 bytes 0xAA,0xBB,0xCC with `s_last` on 0xCC → with the macro: 0xAABBCC8000000000, `m_bytes`=3, `m_last`=1. Without it: 0xAABBCC0000000000. In both cases `frame_cnt` goes 0→1.
- With the macro, 8 bytes 0x11..0x88 with `s_last` on the 8th → two blocks: 0x1122334455667788 with `m_last`=0, then 0x8000000000000000 with `m_bytes`=0 and `m_last`=1. `s_ready`=0 for exactly one cycle.
- `m_ready`=0 while 40 bytes stream in, `DEPTH`=4 → `s_ready` drops after the 32nd byte. Raising `m_ready` drains 0x..., with 4 blocks in order; `s_ready` returns the cycle after the first pop.
- `rst` asserted after 5 bytes of a frame → all outputs go to their reset values immediately. After release, bytes 0x01..0x08 produce 0x0102030405060708 with no residue from the aborted frame.
- 65536 single-byte frames → `frame_cnt` wraps to 0x0000.
